// File: rtl/port_group_dispatch_if.sv
// Handshake bundle between the packet source, the port_group lanes and the order merger.
// The slave modport is the dispatcher's view; master is the surrounding environment.
interface port_group_dispatch_if #(
    parameter int NUM_LANES = 4,
    parameter int META_W    = 64,
    parameter int DATA_W    = 128,
    parameter int EMPTY_W   = 4
) ();
    localparam int LANE_W = $clog2(NUM_LANES);

    logic                 in_meta_valid;
    logic [META_W-1:0]    in_meta_data;
    logic                 in_meta_ready;
    logic                 in_usr_sop;
    logic                 in_usr_eop;
    logic [DATA_W-1:0]    in_usr_data;
    logic [EMPTY_W-1:0]   in_usr_empty;
    logic                 in_usr_valid;
    logic                 in_usr_ready;

    logic [NUM_LANES-1:0] out_meta_valid;
    logic [META_W-1:0]    out_meta_data;
    logic [NUM_LANES-1:0] out_meta_ready;
    logic [NUM_LANES-1:0] out_usr_valid;
    logic                 out_usr_sop;
    logic                 out_usr_eop;
    logic [DATA_W-1:0]    out_usr_data;
    logic [EMPTY_W-1:0]   out_usr_empty;
    logic [NUM_LANES-1:0] out_usr_ready;

    logic [NUM_LANES-1:0] lane_en;
    logic                 order_valid;
    logic [LANE_W-1:0]    order_lane;
    logic                 order_ready;

    modport slave (
        input  in_meta_valid, in_meta_data, in_usr_sop, in_usr_eop, in_usr_data,
               in_usr_empty, in_usr_valid, out_meta_ready, out_usr_ready,
               lane_en, order_ready,
        output in_meta_ready, in_usr_ready, out_meta_valid, out_meta_data,
               out_usr_valid, out_usr_sop, out_usr_eop, out_usr_data, out_usr_empty,
               order_valid, order_lane
    );

    modport master (
        output in_meta_valid, in_meta_data, in_usr_sop, in_usr_eop, in_usr_data,
               in_usr_empty, in_usr_valid, out_meta_ready, out_usr_ready,
               lane_en, order_ready,
        input  in_meta_ready, in_usr_ready, out_meta_valid, out_meta_data,
               out_usr_valid, out_usr_sop, out_usr_eop, out_usr_data, out_usr_empty,
               order_valid, order_lane
    );
endinterface

// File: rtl/port_group_dispatch.sv
// Round-robin whole-packet scheduler over NUM_LANES port_group lanes with an order FIFO for the merger.
// Optional per-lane packet and order-full stall counters when PG_DISPATCH_STATS_EN is defined.
module port_group_dispatch #(
    parameter int NUM_LANES   = 4,
    parameter int ORDER_DEPTH = 32,
    parameter int META_W      = 64,
    parameter int DATA_W      = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    port_group_dispatch_if.slave  bus
`ifdef PG_DISPATCH_STATS_EN
    ,
    output logic [31:0]           lane_pkt_cnt [NUM_LANES],
    output logic [31:0]           order_full_cnt
`endif
);
    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int PTR_W  = $clog2(ORDER_DEPTH);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state;
    logic [LANE_W-1:0]    rr_ptr;
    logic [LANE_W-1:0]    cur_lane;
    logic [LANE_W-1:0]    next_lane;
    logic [NUM_LANES-1:0] lane_oh;
    logic [LANE_W-1:0]    order_mem [ORDER_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       order_cnt;
    logic                 order_full;
    logic                 order_empty;
    logic                 dispatch;
    logic                 release_pkt;
    logic                 order_pop;

    // First enabled lane at or cyclically after start; lowest offset wins.
    function automatic logic [LANE_W-1:0] pick_lane(input logic [NUM_LANES-1:0] en,
                                                    input logic [LANE_W-1:0]    start);
        logic [LANE_W-1:0] sel;
        int idx;
        sel = start;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            idx = int'(start) + i;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            if (en[idx]) sel = LANE_W'(idx);
        end
        return sel;
    endfunction

    assign next_lane   = pick_lane(bus.lane_en, rr_ptr);
    assign order_full  = (order_cnt == (PTR_W+1)'(ORDER_DEPTH));
    assign order_empty = (order_cnt == '0);
    assign dispatch    = (state == IDLE) && bus.in_meta_valid && (|bus.lane_en) && !order_full;
    // lane_oh is zero outside STREAM, so every per-lane term below is gated by state.
    assign release_pkt = bus.in_meta_valid && (|(lane_oh & bus.out_meta_ready));
    assign order_pop   = bus.order_ready && !order_empty;

    assign bus.out_meta_valid = lane_oh & {NUM_LANES{bus.in_meta_valid}};
    assign bus.out_usr_valid  = lane_oh & {NUM_LANES{bus.in_usr_valid}};
    assign bus.in_usr_ready   = |(lane_oh & bus.out_usr_ready);
    assign bus.in_meta_ready  = release_pkt;
    assign bus.out_meta_data  = bus.in_meta_data;
    assign bus.out_usr_sop    = bus.in_usr_sop;
    assign bus.out_usr_eop    = bus.in_usr_eop;
    assign bus.out_usr_data   = bus.in_usr_data;
    assign bus.out_usr_empty  = bus.in_usr_empty;
    assign bus.order_valid    = !order_empty;
    assign bus.order_lane     = order_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            cur_lane <= '0;
            lane_oh  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dispatch) begin
                        state    <= STREAM;
                        cur_lane <= next_lane;
                        lane_oh  <= NUM_LANES'(1) << next_lane;
                    end
                end
                STREAM: begin
                    if (release_pkt) begin
                        state   <= IDLE;
                        lane_oh <= '0;
                        rr_ptr  <= (cur_lane == LANE_W'(NUM_LANES - 1)) ? '0 : cur_lane + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Order FIFO: the lane ID is pushed at dispatch, ahead of any beat of that packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            order_cnt <= '0;
        end else begin
            if (dispatch)  wr_ptr <= wr_ptr + 1'b1;
            if (order_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({dispatch, order_pop})
                2'b10:   order_cnt <= order_cnt + 1'b1;
                2'b01:   order_cnt <= order_cnt - 1'b1;
                default: order_cnt <= order_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (dispatch) order_mem[wr_ptr] <= next_lane;
    end

`ifdef PG_DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) lane_pkt_cnt[i] <= '0;
            order_full_cnt <= '0;
        end else begin
            if ((state == STREAM) && release_pkt) lane_pkt_cnt[cur_lane] <= lane_pkt_cnt[cur_lane] + 1'b1;
            if ((state == IDLE) && bus.in_meta_valid && order_full) order_full_cnt <= order_full_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_port_group_dispatch.sv
// Directed bench for port_group_dispatch: table-driven round-robin vectors plus hand-written
// sequences for back-pressure, order-FIFO full, disabled lanes and mid-packet reset.
module tb_port_group_dispatch;
    logic clk = 1'b0;
    logic rst;
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   acc_cnt [4];

    always #5 clk = ~clk;

    port_group_dispatch_if #(.NUM_LANES(4), .META_W(32), .DATA_W(128), .EMPTY_W(4)) bus ();

    port_group_dispatch #(.NUM_LANES(4), .ORDER_DEPTH(4), .META_W(32), .DATA_W(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial for (int i = 0; i < 4; i++) acc_cnt[i] = 0;

    // Lane-side view: count every beat a lane actually accepts.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bus.out_usr_valid[i] && bus.out_usr_ready[i]) acc_cnt[i] <= acc_cnt[i] + 1;
    end

    typedef struct {
        logic [3:0] en;
        int         nbeats;
        int         exp_lane;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive_beat(input logic [31:0] meta, input int b, input int n);
        bus.in_usr_valid = 1'b1;
        bus.in_usr_sop   = (b == 0);
        bus.in_usr_eop   = (b == n - 1);
        bus.in_usr_data  = {4{meta + 32'(b)}};
        bus.in_usr_empty = 4'(b);
    endtask

    // One packet: IDLE cycle, nbeats beats (optionally stalled), then the lane's meta-ready pulse.
    task automatic run_pkt(input logic [3:0] en, input logic [31:0] meta, input int nbeats,
                           input int lane, input logic orr, input int stall_at, input int stall_n);
        logic [3:0] oh;
        int acc0;
        oh = 4'(1 << lane);
        @(negedge clk);
        bus.lane_en        = en;
        bus.in_meta_valid  = 1'b1;
        bus.in_meta_data   = meta;
        bus.in_usr_valid   = 1'b0;
        bus.out_meta_ready = 4'h0;
        bus.out_usr_ready  = 4'hF;
        bus.order_ready    = orr;
        acc0 = acc_cnt[lane];
        #1;
        chk("idle_meta_vld", 128'(bus.out_meta_valid), 128'(0));
        chk("idle_meta_rdy", 128'(bus.in_meta_ready), 128'(0));
        for (int b = 0; b < nbeats; b++) begin
            if (b == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    drive_beat(meta, b, nbeats);
                    bus.out_usr_ready  = ~oh;
                    bus.out_meta_ready = ~oh;
                    #1;
                    chk("stall_usr_rdy", 128'(bus.in_usr_ready), 128'(0));
                    chk("stall_usr_vld", 128'(bus.out_usr_valid), 128'(oh));
                    chk("stall_meta_rdy", 128'(bus.in_meta_ready), 128'(0));
                end
            end
            @(negedge clk);
            drive_beat(meta, b, nbeats);
            bus.out_usr_ready  = 4'hF;
            bus.out_meta_ready = ~oh;
            #1;
            chk("beat_usr_vld", 128'(bus.out_usr_valid), 128'(oh));
            chk("beat_meta_vld", 128'(bus.out_meta_valid), 128'(oh));
            chk("beat_usr_rdy", 128'(bus.in_usr_ready), 128'(1));
            chk("beat_meta_rdy", 128'(bus.in_meta_ready), 128'(0));
            chk("beat_data", bus.out_usr_data, {4{meta + 32'(b)}});
            chk("beat_frame", 128'({bus.out_usr_sop, bus.out_usr_eop, bus.out_usr_empty}),
                128'({(b == 0), (b == nbeats - 1), 4'(b)}));
            chk("beat_meta_data", 128'(bus.out_meta_data), 128'(meta));
            if (b == 0 && orr) begin
                chk("order_vld", 128'(bus.order_valid), 128'(1));
                chk("order_lane", 128'(bus.order_lane), 128'(lane));
            end
        end
        @(negedge clk);
        bus.in_usr_valid   = 1'b0;
        bus.in_usr_sop     = 1'b0;
        bus.in_usr_eop     = 1'b0;
        bus.out_meta_ready = oh;
        #1;
        chk("rel_meta_rdy", 128'(bus.in_meta_ready), 128'(1));
        chk("rel_usr_vld", 128'(bus.out_usr_valid), 128'(0));
        chk("beats_accepted", 128'(acc_cnt[lane] - acc0), 128'(nbeats));
    endtask

    initial begin
        // Rows 0-5: all lanes enabled; rows 6-9: lanes 1 and 3 only, round-robin pointer starts at 2.
        vecs[0] = '{4'b1111, 1, 0};
        vecs[1] = '{4'b1111, 1, 1};
        vecs[2] = '{4'b1111, 1, 2};
        vecs[3] = '{4'b1111, 1, 3};
        vecs[4] = '{4'b1111, 1, 0};
        vecs[5] = '{4'b1111, 1, 1};
        vecs[6] = '{4'b1010, 2, 3};
        vecs[7] = '{4'b1010, 1, 1};
        vecs[8] = '{4'b1010, 3, 3};
        vecs[9] = '{4'b1010, 1, 1};

        rst = 1'b1;
        bus.in_meta_valid  = 1'b1;
        bus.in_meta_data   = '0;
        bus.in_usr_sop     = 1'b0;
        bus.in_usr_eop     = 1'b0;
        bus.in_usr_data    = '0;
        bus.in_usr_empty   = '0;
        bus.in_usr_valid   = 1'b0;
        bus.out_meta_ready = 4'hF;
        bus.out_usr_ready  = 4'hF;
        bus.lane_en        = 4'hF;
        bus.order_ready    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_meta_vld", 128'(bus.out_meta_valid), 128'(0));
        chk("rst_usr_vld", 128'(bus.out_usr_valid), 128'(0));
        chk("rst_meta_rdy", 128'(bus.in_meta_ready), 128'(0));
        chk("rst_usr_rdy", 128'(bus.in_usr_ready), 128'(0));
        chk("rst_order_vld", 128'(bus.order_valid), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        bus.in_meta_valid = 1'b0;

        for (int i = 0; i < 10; i++)
            run_pkt(vecs[i].en, 32'h1000 + 32'(i * 16), vecs[i].nbeats, vecs[i].exp_lane, 1'b1, -1, 0);

        // Three-beat packet, lane stalls for two cycles before beat 1.
        run_pkt(4'b1111, 32'h2000, 3, 2, 1'b1, 1, 2);

        // Order FIFO fills with lanes 3,0,1,2; a fifth packet must wait in IDLE.
        run_pkt(4'b1111, 32'h3000, 1, 3, 1'b0, -1, 0);
        run_pkt(4'b1111, 32'h3010, 1, 0, 1'b0, -1, 0);
        run_pkt(4'b1111, 32'h3020, 1, 1, 1'b0, -1, 0);
        run_pkt(4'b1111, 32'h3030, 1, 2, 1'b0, -1, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.in_meta_valid  = 1'b1;
            bus.in_meta_data   = 32'h3040;
            bus.out_meta_ready = 4'h0;
            bus.order_ready    = 1'b0;
            #1;
            chk("full_meta_rdy", 128'(bus.in_meta_ready), 128'(0));
            chk("full_meta_vld", 128'(bus.out_meta_valid), 128'(0));
            chk("full_order_vld", 128'(bus.order_valid), 128'(1));
        end
        @(negedge clk);
        bus.order_ready = 1'b1;
        #1;
        chk("full_pop_lane", 128'(bus.order_lane), 128'(3));
        chk("full_pop_meta_vld", 128'(bus.out_meta_valid), 128'(0));
        run_pkt(4'b1111, 32'h3040, 1, 3, 1'b0, -1, 0);
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            bus.in_meta_valid  = 1'b0;
            bus.out_meta_ready = 4'h0;
            bus.order_ready    = 1'b1;
            #1;
            chk("drain_vld", 128'(bus.order_valid), 128'(1));
            chk("drain_lane", 128'(bus.order_lane), 128'(d));
        end
        for (int e = 0; e < 2; e++) begin
            @(negedge clk);
            #1;
            chk("empty_pop_vld", 128'(bus.order_valid), 128'(0));
        end

        // No lane enabled: nothing may move for 10 cycles.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.lane_en        = 4'b0000;
            bus.in_meta_valid  = 1'b1;
            bus.in_meta_data   = 32'h4000;
            bus.order_ready    = 1'b0;
            bus.out_meta_ready = 4'hF;
            #1;
            chk("noen_meta_vld", 128'(bus.out_meta_valid), 128'(0));
            chk("noen_meta_rdy", 128'(bus.in_meta_ready), 128'(0));
            chk("noen_order_vld", 128'(bus.order_valid), 128'(0));
        end
        run_pkt(4'b0100, 32'h4000, 1, 2, 1'b1, -1, 0);

        // Lane 1 packet (wrapping from pointer 3) aborted by reset on beat 2 of 4.
        @(negedge clk);
        bus.lane_en        = 4'b0010;
        bus.in_meta_valid  = 1'b1;
        bus.in_meta_data   = 32'h5000;
        bus.in_usr_valid   = 1'b0;
        bus.out_meta_ready = 4'h0;
        bus.out_usr_ready  = 4'hF;
        bus.order_ready    = 1'b0;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            drive_beat(32'h5000, b, 4);
            #1;
            chk("abort_usr_vld", 128'(bus.out_usr_valid), 128'(4'b0010));
        end
        chk("abort_order_vld", 128'(bus.order_valid), 128'(1));
        @(negedge clk);
        drive_beat(32'h5000, 2, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_meta_valid = 1'b0;
        bus.in_usr_valid  = 1'b0;
        #1;
        chk("after_rst_meta_vld", 128'(bus.out_meta_valid), 128'(0));
        chk("after_rst_usr_vld", 128'(bus.out_usr_valid), 128'(0));
        chk("after_rst_usr_rdy", 128'(bus.in_usr_ready), 128'(0));
        chk("after_rst_order_vld", 128'(bus.order_valid), 128'(0));
        run_pkt(4'b1111, 32'h6000, 2, 0, 1'b1, -1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
